data_mem: RTL and testbench
===========================

# data_mem

Parametrised, byte-addressed, little-endian data memory with a valid/ready request channel and a valid/ready response channel. It supports byte, half-word and word accesses with signed or unsigned extension, and a configurable read/write latency. It reports out-of-range, misaligned and reserved-size accesses through an error flag instead of corrupting memory. It serves as the load/store-stage memory of the processor and replaces the fixed-size, single-cycle byte RAM.

## Interface
- DEPTH, default 256: memory size in bytes; any value ≥ 4.
- LATENCY, default 1: cycles from request acceptance to response valid; legal range 1..15.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low 1, 2 or 4 bytes are used according to size.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result; 0 for stores and for errors.
- resp_err  out  1  access was rejected.

## Operation
- States:
  - IDLE: req_ready = 1.
  - BUSY: waiting out the latency.
  - RESP: resp_valid = 1.
- Acceptance edge: rising edge with req_valid && req_ready. All request fields are sampled only at this edge.
- Error check at acceptance, using n = 1, 2 or 4 bytes:
  - error if req_size == 11;
  - error if req_addr + n − 1 > DEPTH − 1 (computed 33-bit; no wrap-around);
  - error if the access is misaligned (half with addr[0] ≠ 0; word with addr[1:0] ≠ 0), unless DATA_MEM_MISALIGN_EN is defined.
- Store without error: bytes addr..addr+n−1 receive req_wdata[8n−1:0], least-significant byte at addr. The memory is written at the acceptance edge.
- Erroneous store: memory is unchanged.
- Load without error: bytes are read at the acceptance edge, assembled little-endian and extended from bit 8n−1 (sign or zero per req_signed). The result is held in the response register.
- Load after store: a load accepted after a store's acceptance sees the stored data.
- State transitions:
  - IDLE → BUSY on acceptance when LATENCY > 1; IDLE → RESP when LATENCY = 1.
  - BUSY: a 4-bit counter counts LATENCY − 1 edges, then moves to RESP.
  - RESP → IDLE on the edge with resp_ready = 1.
- Memory array has no reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Acceptance at edge E0 → resp_valid rises after edge E0 + LATENCY.
- Response handshake and recovery:
  - resp_valid, resp_rdata and resp_err stay stable while resp_ready = 0.
  - Handshake at edge Ek → resp_valid = 0 and req_ready = 1 after Ek.
  - Minimum request period is LATENCY + 1 cycles.
- req_ready = 0 in BUSY and RESP. Requests presented then are not accepted and have no effect.
- No combinational path from req_* or resp_ready to any output; all outputs are registered or decoded from state only.
- Reset asserted mid-operation (BUSY or RESP): outputs go to reset values immediately; the pending response is discarded.
- A store whose acceptance edge completed before reset remains in memory.
- resp_ready high while in IDLE or BUSY: ignored.

## Configuration
- DATA_MEM_MISALIGN_EN defined: misaligned half and word accesses are legal when fully in range. They are performed bytewise with the same little-endian layout and resp_err = 0.
- DATA_MEM_MISALIGN_EN undefined: misaligned accesses set resp_err = 1, do not write memory and return resp_rdata = 0.
- Range and reserved-size checks are identical in both builds.

## Test plan
- DEPTH = 256, LATENCY = 1, resp_ready tied high:
  - word store 0xF00FF176 @200 → response err = 0;
  - word load @200 → 0xF00FF176;
  - signed half load @200 → 0xFFFFF176;
  - unsigned half load @200 → 0x0000F176;
  - signed byte load @203 → 0xFFFFFFF0.
- Word store 0x12345678 @201, macro undefined → resp_err = 1; word load @200 still returns 0xF00FF176. With the macro defined, the same store gives err = 0 and a byte load @201 returns 0x00000078.
- Word load @253 with DEPTH = 256 → resp_err = 1, rdata = 0. Req_size = 11 @0 → resp_err = 1.
- LATENCY = 4, load accepted at edge 10 → resp_valid first high after edge 14. Hold resp_ready low for 5 cycles → rdata and err stable and req_ready = 0 throughout. Handshake at the next edge → req_ready = 1.
- Assert rst for half a cycle while in BUSY (LATENCY = 4) → resp_valid = 0 and req_ready = 1 immediately, with no response ever produced. A following load of earlier-stored data returns the correct value.

Source files
------------

// File: rtl/data_mem_if.sv
// data_mem_if: request/response channel bundle for the data_mem load/store memory.
// The master side issues byte/half/word loads and stores and consumes responses.
// The slave side (the memory) accepts requests and produces responses.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_write,
        output req_size,
        output req_signed,
        output req_addr,
        output req_wdata,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_size,
        input  req_signed,
        input  req_addr,
        input  req_wdata,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );
endinterface

// File: rtl/data_mem.sv
// data_mem: byte-addressed, little-endian data memory for the load/store stage.
// Byte/half/word accesses with sign or zero extension on loads, a fixed
// request-to-response latency of LATENCY cycles, and an error flag for
// reserved size, out-of-range and (by default) misaligned accesses.
// Optional feature macro: DATA_MEM_MISALIGN_EN -- when defined, misaligned
// half/word accesses that are fully in range are performed bytewise.
// All request fields are consumed on the accepting clock edge; stores write
// the array on that same edge, loads capture their result into the response
// register on that edge.
module data_mem #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  mem_bus
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LAST_ADDR = 33'(DEPTH - 1);
    localparam logic [3:0]  CNT_LAST  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // With a one-cycle latency the response is ready straight after acceptance.
    localparam state_t ACC_STATE = (LATENCY > 1) ? S_BUSY : S_RESP;

    // State, latency counter and response holding registers.
    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_rdata;
    logic        r_err;

    // Byte storage; deliberately not reset.
    logic [7:0]  r_mem [0:DEPTH-1];

    // Request decode.
    logic          w_accept;
    logic [2:0]    w_nbytes;
    logic          w_size_err;
    logic          w_range_err;
    logic          w_align_err;
    logic          w_err;
    logic [32:0]   w_last_addr;
    logic [AW-1:0] w_idx      [4];
    logic          w_lane_en  [4];
    logic [7:0]    w_rd_byte  [4];
    logic [31:0]   w_raw;
    logic [31:0]   w_load_data;
    logic [31:0]   w_resp_data;

    // Output decode.
    logic          w_req_ready;
    logic          w_resp_valid;

    assign w_accept = mem_bus.req_valid && (r_state == S_IDLE);

    // Decode access width and reserved size.
    always_comb begin
        w_nbytes   = 3'd4;
        w_size_err = 1'b0;
        case (mem_bus.req_size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            2'b10:   w_nbytes = 3'd4;
            default: begin
                w_nbytes   = 3'd4;
                w_size_err = 1'b1;
            end
        endcase
    end

    // Range check on the last touched byte, done in 33 bits so a high address cannot wrap back in range.
    always_comb begin
        w_last_addr = {1'b0, mem_bus.req_addr} + 33'(w_nbytes) - 33'd1;
        if (w_last_addr > LAST_ADDR) begin
            w_range_err = 1'b1;
        end else begin
            w_range_err = 1'b0;
        end
    end

`ifdef DATA_MEM_MISALIGN_EN
    // Misaligned accesses are legal in this build; they are handled bytewise.
    always_comb begin
        w_align_err = 1'b0;
    end
`else
    // Half words must sit on even addresses, words on multiples of four.
    always_comb begin
        w_align_err = 1'b0;
        case (mem_bus.req_size)
            2'b01:   w_align_err = mem_bus.req_addr[0];
            2'b10:   w_align_err = (mem_bus.req_addr[1:0] != 2'b00);
            default: w_align_err = 1'b0;
        endcase
    end
`endif

    assign w_err = w_size_err || w_range_err || w_align_err;

    // Per-lane byte index and enable; lane i maps to byte address addr+i.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_idx[i]     = mem_bus.req_addr[AW-1:0] + AW'(i);
            w_lane_en[i] = (3'(i) < w_nbytes);
        end
    end

    // Read the enabled lanes from the array; disabled lanes read as zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (w_lane_en[i]) begin
                w_rd_byte[i] = r_mem[w_idx[i]];
            end else begin
                w_rd_byte[i] = 8'h00;
            end
        end
    end

    assign w_raw = {w_rd_byte[3], w_rd_byte[2], w_rd_byte[1], w_rd_byte[0]};

    // Extend the assembled value from its top bit according to access width.
    always_comb begin
        w_load_data = w_raw;
        case (mem_bus.req_size)
            2'b00:   w_load_data = {{24{mem_bus.req_signed & w_raw[7]}},  w_raw[7:0]};
            2'b01:   w_load_data = {{16{mem_bus.req_signed & w_raw[15]}}, w_raw[15:0]};
            default: w_load_data = w_raw;
        endcase
    end

    // Stores and rejected accesses return zero data.
    always_comb begin
        if (w_err || mem_bus.req_write) begin
            w_resp_data = 32'h0000_0000;
        end else begin
            w_resp_data = w_load_data;
        end
    end

    // Array write on the accepting edge for error-free stores only.
    always_ff @(posedge clk) begin
        if (w_accept && mem_bus.req_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_en[i]) begin
                    r_mem[w_idx[i]] <= mem_bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // FSM state register and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // FSM next-state logic: IDLE accepts, BUSY counts out the latency, RESP waits for the consumer.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = ACC_STATE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = 4'd0;
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = S_RESP;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_next_state = S_BUSY;
                    w_cnt_next   = r_cnt + 4'd1;
                end
            end
            S_RESP: begin
                if (mem_bus.resp_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
                w_cnt_next = 4'd0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Response register: captured once at acceptance and held until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_resp_data;
            r_err   <= w_err;
        end
    end

    // FSM outputs decoded from the state register only.
    always_comb begin
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready  = 1'b1;
                w_resp_valid = 1'b0;
            end
            S_BUSY: begin
                w_req_ready  = 1'b0;
                w_resp_valid = 1'b0;
            end
            S_RESP: begin
                w_req_ready  = 1'b0;
                w_resp_valid = 1'b1;
            end
            default: begin
                w_req_ready  = 1'b0;
                w_resp_valid = 1'b0;
            end
        endcase
    end

    assign mem_bus.req_ready  = w_req_ready;
    assign mem_bus.resp_valid = w_resp_valid;
    assign mem_bus.resp_rdata = r_rdata;
    assign mem_bus.resp_err   = r_err;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: scoreboard bench for data_mem. Two instances (LATENCY 1 and 4,
// DEPTH 256) are driven; expected responses come from a byte-array model and
// are queued at acceptance, and a negedge monitor pops and compares them.
module tb_data_mem;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    data_mem_if bus1 ();
    data_mem_if bus4 ();

    data_mem #(.DEPTH(256), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .mem_bus(bus1));
    data_mem #(.DEPTH(256), .LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .mem_bus(bus4));

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t      q1[$];
    resp_t      q4[$];
    logic [7:0] mdl [2][256];
    int         errors = 0;
    int         checks = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference behaviour: n-byte little-endian access into a 256-byte array.
    function automatic resp_t model(int w, logic wr, logic [1:0] sz, logic sg,
                                    logic [31:0] a, logic [31:0] wd);
        int     n;
        logic   e;
        longint v;
        resp_t  r;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = (sz == 2'd3) || ((longint'(a) + n - 1) > 255);
`ifndef DATA_MEM_MISALIGN_EN
        if ((sz != 2'd3) && ((a % n) != 0)) e = 1'b1;
`endif
        v = 0;
        if (!e && wr) begin
            for (int i = 0; i < n; i++) mdl[w][int'(a) + i] = wd[8*i +: 8];
        end
        if (!e && !wr) begin
            for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(mdl[w][int'(a) + i]);
            if (sg && (v >= (longint'(1) << (8*n - 1)))) v = v - (longint'(1) << (8*n));
        end
        r.rdata = 32'(v);
        r.err   = e;
        return r;
    endfunction

    task automatic send_core(int w, logic wr, logic [1:0] sz, logic sg, logic [31:0] a,
                             logic [31:0] wd, bit use_exp, logic [31:0] xr, logic xe);
        int    guard;
        logic  rdy;
        resp_t e;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            rdy = (w == 0) ? bus1.req_ready : bus4.req_ready;
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: dut %0d never ready at %0t", w, $time);
            return;
        end
        if (w == 0) begin
            bus1.req_write = wr; bus1.req_size = sz; bus1.req_signed = sg;
            bus1.req_addr = a; bus1.req_wdata = wd; bus1.req_valid = 1'b1;
        end else begin
            bus4.req_write = wr; bus4.req_size = sz; bus4.req_signed = sg;
            bus4.req_addr = a; bus4.req_wdata = wd; bus4.req_valid = 1'b1;
        end
        @(posedge clk);
        e = model(w, wr, sz, sg, a, wd);
        if (use_exp) begin
            e.rdata = xr;
            e.err   = xe;
        end
        if (w == 0) q1.push_back(e);
        else        q4.push_back(e);
        #1;
        bus1.req_valid = 1'b0;
        bus4.req_valid = 1'b0;
    endtask

    task automatic send(int w, logic wr, logic [1:0] sz, logic sg, logic [31:0] a, logic [31:0] wd);
        send_core(w, wr, sz, sg, a, wd, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic send_exp(int w, logic wr, logic [1:0] sz, logic sg, logic [31:0] a,
                            logic [31:0] wd, logic [31:0] xr, logic xe);
        send_core(w, wr, sz, sg, a, wd, 1'b1, xr, xe);
    endtask

    // Monitor: every response handshake pops one expected entry and compares it.
    always @(negedge clk) begin
        resp_t e1;
        resp_t e4;
        if (bus1.resp_valid && bus1.resp_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp1_unexpected: got rdata 0x%08h err %0b with nothing pending", bus1.resp_rdata, bus1.resp_err);
            end else begin
                e1 = q1.pop_front();
                chk("resp1_rdata", bus1.resp_rdata, e1.rdata);
                chk("resp1_err", 32'(bus1.resp_err), 32'(e1.err));
            end
        end
        if (bus4.resp_valid && bus4.resp_ready) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp4_unexpected: got rdata 0x%08h err %0b with nothing pending", bus4.resp_rdata, bus4.resp_err);
            end else begin
                e4 = q4.pop_front();
                chk("resp4_rdata", bus4.resp_rdata, e4.rdata);
                chk("resp4_err", 32'(bus4.resp_err), 32'(e4.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_rd;
        logic        hold_er;
        int          guard;

        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_size = 2'd0; bus1.req_signed = 1'b0;
        bus1.req_addr = 32'd0; bus1.req_wdata = 32'd0; bus1.resp_ready = 1'b1;
        bus4.req_valid = 1'b0; bus4.req_write = 1'b0; bus4.req_size = 2'd0; bus4.req_signed = 1'b0;
        bus4.req_addr = 32'd0; bus4.req_wdata = 32'd0; bus4.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst1_req_ready",  32'(bus1.req_ready),  32'd1);
        chk("rst1_resp_valid", 32'(bus1.resp_valid), 32'd0);
        chk("rst1_rdata",      bus1.resp_rdata,      32'd0);
        chk("rst1_err",        32'(bus1.resp_err),   32'd0);
        chk("rst4_req_ready",  32'(bus4.req_ready),  32'd1);
        chk("rst4_resp_valid", 32'(bus4.resp_valid), 32'd0);
        chk("rst4_rdata",      bus4.resp_rdata,      32'd0);
        chk("rst4_err",        32'(bus4.resp_err),   32'd0);

        // Give every byte a defined value in both instances.
        for (int a = 0; a < 256; a += 4) begin
            send(0, 1'b1, 2'd2, 1'b0, 32'(a), $urandom);
            send(1, 1'b1, 2'd2, 1'b0, 32'(a), $urandom);
        end

        // Directed accesses at LATENCY 1.
        send_exp(0, 1'b1, 2'd2, 1'b0, 32'd200, 32'hF00F_F176, 32'h0000_0000, 1'b0);
        send_exp(0, 1'b0, 2'd2, 1'b0, 32'd200, 32'h0,        32'hF00F_F176, 1'b0);
        send_exp(0, 1'b0, 2'd1, 1'b1, 32'd200, 32'h0,        32'hFFFF_F176, 1'b0);
        send_exp(0, 1'b0, 2'd1, 1'b0, 32'd200, 32'h0,        32'h0000_F176, 1'b0);
        send_exp(0, 1'b0, 2'd0, 1'b1, 32'd203, 32'h0,        32'hFFFF_FFF0, 1'b0);
`ifdef DATA_MEM_MISALIGN_EN
        send_exp(0, 1'b1, 2'd2, 1'b0, 32'd201, 32'h1234_5678, 32'h0000_0000, 1'b0);
        send_exp(0, 1'b0, 2'd0, 1'b0, 32'd201, 32'h0,         32'h0000_0078, 1'b0);
        send_exp(0, 1'b0, 2'd2, 1'b0, 32'd200, 32'h0,         32'h3456_7876, 1'b0);
`else
        send_exp(0, 1'b1, 2'd2, 1'b0, 32'd201, 32'h1234_5678, 32'h0000_0000, 1'b1);
        send_exp(0, 1'b0, 2'd2, 1'b0, 32'd200, 32'h0,         32'hF00F_F176, 1'b0);
`endif
        send_exp(0, 1'b0, 2'd2, 1'b0, 32'd253, 32'h0, 32'h0000_0000, 1'b1);
        send_exp(0, 1'b0, 2'd3, 1'b0, 32'd0,   32'h0, 32'h0000_0000, 1'b1);
        send_exp(0, 1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 1'b1);

        // LATENCY 4: response timing and stall behaviour.
        send(1, 1'b1, 2'd2, 1'b0, 32'd100, 32'h8BAD_F00D);
        guard = 0;
        while (q4.size() != 0 && guard < 50) begin @(negedge clk); guard++; end
        bus4.resp_ready = 1'b0;
        send_exp(1, 1'b0, 2'd2, 1'b0, 32'd100, 32'h0, 32'h8BAD_F00D, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat4_valid_low", 32'(bus4.resp_valid), 32'd0);
        end
        @(negedge clk);
        chk("lat4_valid_high", 32'(bus4.resp_valid), 32'd1);
        hold_rd = bus4.resp_rdata;
        hold_er = bus4.resp_err;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid",     32'(bus4.resp_valid), 32'd1);
            chk("hold_rdata",     bus4.resp_rdata,      hold_rd);
            chk("hold_err",       32'(bus4.resp_err),   32'(hold_er));
            chk("hold_req_ready", 32'(bus4.req_ready),  32'd0);
        end
        @(posedge clk);
        #1 bus4.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("after_hs_req_ready",  32'(bus4.req_ready),  32'd1);
        chk("after_hs_resp_valid", 32'(bus4.resp_valid), 32'd0);

        // Reset during BUSY discards the pending response but keeps stored data.
        send(1, 1'b1, 2'd2, 1'b0, 32'd40, 32'hA5C3_0F96);
        send(1, 1'b0, 2'd2, 1'b0, 32'd40, 32'h0);
        @(posedge clk);
        #1;
        chk("busy_req_ready", 32'(bus4.req_ready), 32'd0);
        rst = 1'b1;
        q4.delete();
        #1;
        chk("midrst_resp_valid", 32'(bus4.resp_valid), 32'd0);
        chk("midrst_req_ready",  32'(bus4.req_ready),  32'd1);
        chk("midrst_rdata",      bus4.resp_rdata,      32'd0);
        #4 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("postrst_no_resp", 32'(bus4.resp_valid), 32'd0);
        end
        send_exp(1, 1'b0, 2'd2, 1'b0, 32'd40, 32'h0, 32'hA5C3_0F96, 1'b0);
        send_exp(1, 1'b0, 2'd1, 1'b1, 32'd42, 32'h0, 32'hFFFF_A5C3, 1'b0);

        // Randomised mix of loads and stores on both instances.
        for (int i = 0; i < 300; i++) begin
            int          w;
            int          r;
            int          mode;
            int          n;
            logic [1:0]  sz;
            logic [31:0] a;
            w    = i % 2;
            r    = $urandom_range(0, 9);
            sz   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            mode = $urandom_range(0, 7);
            if (mode == 0)      a = $urandom;
            else if (mode == 1) a = 32'(248 + $urandom_range(0, 15));
            else if (mode < 6)  a = 32'($urandom_range(0, 255)) & ~32'(n - 1);
            else                a = 32'($urandom_range(0, 255));
            send(w, ($urandom_range(0, 2) == 0), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        guard = 0;
        while ((q1.size() != 0 || q4.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
